// File: rtl/booth_seq_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// booth_seq_multiplier_pkg
//   Shared definitions for the sequential radix-4 Booth multiplier:
//   FSM state encodings and helpers for the iteration count and the width
//   of the iteration counter.
// ---------------------------------------------------------------------------
package booth_seq_multiplier_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Number of radix-4 triplets needed for an unsigned WORDLEN x WORDLEN
   // multiply: WORDLEN/2 groups for the operand plus one extra group so
   // that the top digit sees the zero pad and is never negative.
   function automatic int booth_niter(input int wordlen);
      return wordlen / 2 + 1;
   endfunction

   // Width of the iteration counter: it must hold 0..NITER.
   function automatic int booth_cnt_w(input int wordlen);
      return $clog2(booth_niter(wordlen) + 1);
   endfunction

endpackage

// File: rtl/booth_seq_multiplier_enc.sv
// ---------------------------------------------------------------------------
// booth_seq_multiplier_enc
//   Radix-4 Booth encoder cell. Given the multiplicand and one overlapping
//   multiplier triplet, produces the one's-complement partial product and
//   its sign. The caller completes the two's complement by sign-extending
//   result with sign and adding sign at the LSB.
//
// Ports
//   a       in   WORDLEN     multiplicand (unsigned)
//   s       in   3           triplet {b[2i+1], b[2i], b[2i-1]}
//   result  out  WORDLEN+1   |digit|*a, inverted when sign=1
//   sign    out  1           digit is negative (triplet MSB)
// ---------------------------------------------------------------------------
module booth_seq_multiplier_enc #(
   parameter int WORDLEN = 32
) (
   input  logic [WORDLEN-1:0] a,
   input  logic [2:0]         s,
   output logic [WORDLEN:0]   result,
   output logic               sign
);

   logic           sel_one;
   logic           sel_two;
   logic [WORDLEN:0] a_x1;
   logic [WORDLEN:0] a_x2;

   // Digit = -2*s[2] + s[1] + s[0]. |digit|=1 when s[1]^s[0]; |digit|=2
   // for 011 and 100. For 111 the magnitude is zero while sign stays set,
   // which the caller's +1 turns back into exactly zero.
   assign sel_one = s[1] ^ s[0];
   assign sel_two = (s == 3'b011) || (s == 3'b100);
   assign sign    = s[2];

   assign a_x1 = {1'b0, a};
   assign a_x2 = {a, 1'b0};

   generate
      for (genvar gi = 0; gi <= WORDLEN; gi++) begin : g_bit
         assign result[gi] = ((sel_one & a_x1[gi]) | (sel_two & a_x2[gi])) ^ sign;
      end
   endgenerate

endmodule

// File: rtl/booth_seq_multiplier.sv
// ---------------------------------------------------------------------------
// booth_seq_multiplier
//   Sequential radix-4 Booth multiplier, unsigned x unsigned. One triplet is
//   encoded per cycle by the Booth encoder cell; the sign-corrected partial
//   product is shifted to its weight and added into a 2*WORDLEN+2 bit
//   accumulator. Valid/ready handshakes on input and output.
//
// Ports
//   clk        in   1           clock, rising edge
//   rst        in   1           synchronous active-high reset
//   in_valid   in   1           operands a/b valid
//   in_ready   out  1           operands accepted (IDLE only)
//   a          in   WORDLEN     multiplicand
//   b          in   WORDLEN     multiplier
//   out_valid  out  1           product valid, held until out_ready
//   out_ready  in   1           consumer accepts product
//   product    out  2*WORDLEN   a*b
//   busy       out  1           operation in progress or result pending
//
// Timing: the accept edge is edge 0; triplet i is accumulated on edge i+1,
// so out_valid is high after edge NITER. With out_ready high the DONE state
// lasts one cycle and a new operand can be accepted NITER+2 edges after the
// previous accept.
// ---------------------------------------------------------------------------
module booth_seq_multiplier
   import booth_seq_multiplier_pkg::*;
#(
   parameter int WORDLEN = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORDLEN-1:0]     a,
   input  logic [WORDLEN-1:0]     b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*WORDLEN-1:0]   product,
   output logic                   busy
);

   localparam int NITER = booth_niter(WORDLEN);
   localparam int CNT_W = booth_cnt_w(WORDLEN);
   localparam int ACC_W = 2 * WORDLEN + 2;
   localparam int BX_W  = WORDLEN + 3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NITER - 1);

   logic [1:0]         state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg,   cnt_next;
   logic [WORDLEN-1:0] a_reg,     a_next;
   logic [BX_W-1:0]    bx_reg,    bx_next;
   logic [ACC_W-1:0]   acc_reg,   acc_next;

   logic [WORDLEN:0]   enc_result;
   logic               enc_sign;
   logic [ACC_W-1:0]   pp_full;
   logic [ACC_W-1:0]   pp_shifted;

   // The multiplier register shifts right by two each RUN cycle, so the
   // current triplet is always its three LSBs.
   booth_seq_multiplier_enc #(
      .WORDLEN (WORDLEN)
   ) u_enc (
      .a      (a_reg),
      .s      (bx_reg[2:0]),
      .result (enc_result),
      .sign   (enc_sign)
   );

   // Sign-extend the one's-complement result and fold in the +1, giving the
   // two's-complement partial product; then weight it by 4^i.
   assign pp_full    = {{(WORDLEN + 1){enc_sign}}, enc_result} + ACC_W'(enc_sign);
   assign pp_shifted = pp_full << {cnt_reg, 1'b0};

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      a_next     = a_reg;
      bx_next    = bx_reg;
      acc_next   = acc_reg;
      case (state_reg)
         ST_IDLE: begin
            if (in_valid) begin
               state_next = ST_RUN;
               cnt_next   = '0;
               a_next     = a;
               // Zero pad above b keeps the top digit non-negative.
               bx_next    = {2'b00, b, 1'b0};
               acc_next   = '0;
            end
         end
         ST_RUN: begin
            acc_next = acc_reg + pp_shifted;
            bx_next  = bx_reg >> 2;
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_LAST) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         a_reg     <= '0;
         bx_reg    <= '0;
         acc_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         a_reg     <= a_next;
         bx_reg    <= bx_next;
         acc_reg   <= acc_next;
      end
   end

   assign in_ready  = (state_reg == ST_IDLE) && !rst;
   assign out_valid = (state_reg == ST_DONE);
   assign busy      = (state_reg != ST_IDLE);
   assign product   = acc_reg[2*WORDLEN-1:0];

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_multiplier
//   Two instances: WORDLEN=8 for directed/table vectors and multi-cycle
//   corner sequences, WORDLEN=32 for randomized back-to-back traffic with a
//   random consumer. Expected products come from plain a*b arithmetic.
// ---------------------------------------------------------------------------
module tb_booth_seq_multiplier;

   localparam int NITER8 = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

   logic        in_valid32, in_ready32, out_valid32, out_ready32, busy32;
   logic [31:0] a32, b32;
   logic [63:0] product32;

   int checks   = 0;
   int failures = 0;

   booth_seq_multiplier #(.WORDLEN(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
      .product(product8), .busy(busy8)
   );

   booth_seq_multiplier #(.WORDLEN(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
      .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32),
      .product(product32), .busy(busy32)
   );

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for in_ready, present operands for exactly one accept edge.
   // Returns just after the accept edge (edge 0).
   task automatic send8(input logic [7:0] a, input logic [7:0] b);
      int guard = 0;
      while (!in_ready8 && guard < 50) begin
         tick();
         guard++;
      end
      chk("send8_in_ready", 64'(in_ready8), 64'd1);
      a8        = a;
      b8        = b;
      in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
   endtask

   // Called right after the accept edge; waits for out_valid and checks
   // latency, product, and (if rel) a one-cycle-wide out_valid.
   task automatic result8(input string name, input logic [15:0] exp, input bit rel);
      int lat = 0;
      bit ready_seen = 1'b0;
      while (!out_valid8 && lat < 20) begin
         if (in_ready8 || !busy8) ready_seen = 1'b1;
         tick();
         lat++;
      end
      chk({name, "_latency"}, 64'(lat), 64'(NITER8));
      chk({name, "_in_ready_low"}, 64'(ready_seen | in_ready8), 64'd0);
      chk({name, "_product"}, 64'(product8), 64'(exp));
      chk({name, "_acc_upper"}, 64'(dut8.acc_reg[17:16]), 64'd0);
      $display("op8 %s a=%0d b=%0d product=%0h exp=%0h lat=%0d", name, a8, b8, product8, exp, lat);
      if (rel) begin
         tick();
         chk({name, "_one_wide"}, 64'(out_valid8), 64'd0);
         chk({name, "_ready_again"}, 64'(in_ready8), 64'd1);
      end
   endtask

   initial begin
      rst         = 1'b1;
      in_valid8   = 1'b0;
      in_valid32  = 1'b0;
      out_ready8  = 1'b1;
      out_ready32 = 1'b0;
      a8 = '0; b8 = '0; a32 = '0; b32 = '0;

      vecs[0] = '{8'd7,   8'd6,   16'd42};
      vecs[1] = '{8'hFF,  8'hFF,  16'hFE01};
      vecs[2] = '{8'h80,  8'hAA,  16'h5500};
      vecs[3] = '{8'h00,  8'h5A,  16'h0000};
      vecs[4] = '{8'h5A,  8'h00,  16'h0000};
      vecs[5] = '{8'd1,   8'd1,   16'd1};
      vecs[6] = '{8'hFF,  8'd1,   16'h00FF};
      vecs[7] = '{8'h55,  8'h33,  16'h10EF};

      // Reset state
      tick();
      tick();
      chk("rst_in_ready_during", 64'(in_ready8), 64'd0);
      chk("rst_out_valid", 64'(out_valid8), 64'd0);
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_product", 64'(product8), 64'd0);
      chk("rst_out_valid32", 64'(out_valid32), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready_after", 64'(in_ready8), 64'd1);
      chk("rst_in_ready32_after", 64'(in_ready32), 64'd1);

      // Table-driven vectors, out_ready tied high
      for (int i = 0; i < 8; i++) begin
         send8(vecs[i].a, vecs[i].b);
         result8($sformatf("vec%0d", i), vecs[i].exp, 1'b1);
      end

      // Random 8-bit operands against plain arithmetic
      for (int i = 0; i < 20; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         send8(ra, rb);
         result8($sformatf("rnd8_%0d", i), 16'(ra) * 16'(rb), 1'b1);
      end

      // Output held off: product and out_valid stable, in_valid ignored
      out_ready8 = 1'b0;
      send8(8'd7, 8'd6);
      result8("hold", 16'd42, 1'b0);
      for (int i = 0; i < 10; i++) begin
         a8        = 8'($urandom);
         b8        = 8'($urandom);
         in_valid8 = i[0];
         tick();
         chk("hold_out_valid", 64'(out_valid8), 64'd1);
         chk("hold_product", 64'(product8), 64'd42);
      end
      // Same-edge out_ready and in_valid: the new op waits one cycle
      a8         = 8'd3;
      b8         = 8'd9;
      in_valid8  = 1'b1;
      out_ready8 = 1'b1;
      tick();
      chk("same_edge_not_accepted", 64'(busy8), 64'd0);
      chk("same_edge_in_ready", 64'(in_ready8), 64'd1);
      tick();
      in_valid8 = 1'b0;
      chk("next_edge_accepted", 64'(busy8), 64'd1);
      result8("after_hold", 16'd27, 1'b1);

      // Reset in the middle of RUN
      send8(8'd3, 8'd5);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_out_valid", 64'(out_valid8), 64'd0);
      chk("midrst_busy", 64'(busy8), 64'd0);
      chk("midrst_product", 64'(product8), 64'd0);
      rst = 1'b0;
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid8) seen = 1'b1;
         end
         chk("midrst_no_result", 64'(seen), 64'd0);
      end
      send8(8'd2, 8'd2);
      result8("post_rst", 16'd4, 1'b1);

      // 32-bit random back-to-back traffic with a random consumer
      begin
         int          n_ops = 2000;
         logic [63:0] exp_q[$];
         fork
            begin : producer
               for (int i = 0; i < n_ops; i++) begin
                  logic was;
                  int   guard;
                  case (i)
                     0:       begin a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; end
                     1:       begin a32 = 32'h0;         b32 = 32'h1234_5678; end
                     2:       begin a32 = 32'h8000_0000; b32 = 32'hAAAA_AAAA; end
                     default: begin a32 = $urandom;      b32 = $urandom;      end
                  endcase
                  in_valid32 = 1'b1;
                  guard = 0;
                  do begin
                     was = in_ready32;
                     tick();
                     guard++;
                  end while (!was && guard < 200);
                  if (!was) begin
                     chk("rnd32_accept_timeout", 64'd0, 64'd1);
                     break;
                  end
                  exp_q.push_back(64'(a32) * 64'(b32));
               end
               in_valid32 = 1'b0;
            end
            begin : consumer
               int          got = 0;
               int          cyc = 0;
               bit          holding = 1'b0;
               logic [63:0] held = '0;
               while (got < n_ops && cyc < 70000) begin
                  out_ready32 = 1'($urandom_range(0, 1));
                  if (out_valid32) begin
                     if (holding) chk("rnd32_stable", product32, held);
                     if (out_ready32) begin
                        if (exp_q.size() == 0) begin
                           chk("rnd32_unexpected_result", 64'd1, 64'd0);
                        end else begin
                           logic [63:0] e;
                           e = exp_q.pop_front();
                           chk("rnd32_product", product32, e);
                           chk("rnd32_acc_upper", 64'(dut32.acc_reg[65:64]), 64'd0);
                           $display("op32 n=%0d product=%0h exp=%0h", got, product32, e);
                        end
                        got++;
                        holding = 1'b0;
                     end else begin
                        holding = 1'b1;
                        held    = product32;
                     end
                  end
                  tick();
                  cyc++;
               end
               out_ready32 = 1'b0;
               chk("rnd32_count", 64'(got), 64'(n_ops));
            end
         join
         chk("rnd32_queue_empty", 64'(exp_q.size()), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
